// File: rtl/aes_iter_ctrl_if.sv
// Request/response bundle between the bus adapter and the iterative AES controller.
// master: the bus adapter (drives requests, accepts ciphertext).
// slave : the controller (accepts requests, presents ciphertext).
interface aes_iter_ctrl_if #(
  parameter int Nkb = 128
);
  logic           in_valid;      // request valid
  logic           in_ready;      // controller can accept a request
  logic [127:0]   in_data;       // plaintext, MSB = byte 0
  logic [Nkb-1:0] in_key;        // cipher key
  logic           in_key_reuse;  // 1 = reuse the previously expanded key
  logic           out_valid;     // ciphertext valid
  logic           out_ready;     // consumer accepts ciphertext
  logic [127:0]   out_data;      // ciphertext

  modport master (
    output in_valid, in_data, in_key, in_key_reuse, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_key_reuse, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_iter_ctrl.sv
// Sequences one external AES round datapath over Nr rounds and drives an external key expander.
// Latency: Nr+1 edges from accept to out_valid on key reuse; +1 (KEXP) + ks_done wait on a new key.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, stalling new requests.
//
// Ports:
//   clk, rst     : single clock, asynchronous active-high reset
//   bus (slave)  : request (in_valid/in_ready/in_data/in_key/in_key_reuse) and
//                  response (out_valid/out_ready/out_data) handshakes
//   ks_start     : one-cycle pulse asking the expander to expand ks_key
//   ks_key       : registered copy of the accepted key
//   ks_done      : expander finished (level or pulse), sampled only in WAITK
//   rk_idx/rk_i  : round-key index into the expanded schedule and the key it selects
//   rnd_state_o  : state fed to the round datapath (the state register)
//   rnd_last     : final round, datapath skips MixColumns
//   rnd_state_i  : round datapath result
module aes_iter_ctrl #(
  parameter int Nk = 4,
  parameter int Nr = 10,
  localparam int Nkb = Nk * 32
) (
  input  logic            clk,
  input  logic            rst,
  aes_iter_ctrl_if.slave  bus,
  output logic            ks_start,
  output logic [Nkb-1:0]  ks_key,
  input  logic            ks_done,
  output logic [3:0]      rk_idx,
  input  logic [127:0]    rk_i,
  output logic [127:0]    rnd_state_o,
  output logic            rnd_last,
  input  logic [127:0]    rnd_state_i
);

  typedef enum logic [2:0] {
    IDLE,
    KEXP,
    WAITK,
    ADD0,
    ROUND,
    DONE
  } fsm_t;

  localparam logic [3:0] NR = 4'(Nr);

  fsm_t         fsm;
  logic [127:0] state;
  logic [3:0]   cnt;
  logic         key_ok;     // expander holds a schedule for the current ks_key
  logic         in_ready_q;
  logic         out_valid_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = state;
  assign rnd_state_o   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= IDLE;
      state       <= '0;
      cnt         <= '0;
      key_ok      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ks_start    <= 1'b0;
      ks_key      <= '0;
      rk_idx      <= '0;
      rnd_last    <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            state      <= bus.in_data;
            ks_key     <= bus.in_key;
            in_ready_q <= 1'b0;
            rk_idx     <= '0;
            if (bus.in_key_reuse && key_ok) begin
              fsm <= ADD0;
            end else begin
              // Reuse without a valid schedule falls back to a fresh expansion.
              key_ok   <= 1'b0;
              ks_start <= 1'b1;
              fsm      <= KEXP;
            end
          end
        end

        KEXP: begin
          // ks_done may still be high from an earlier expansion; ignore it here.
          ks_start <= 1'b0;
          fsm      <= WAITK;
        end

        WAITK: begin
          if (ks_done) begin
            key_ok <= 1'b1;
            rk_idx <= '0;
            fsm    <= ADD0;
          end
        end

        ADD0: begin
          // Initial AddRoundKey with rk_idx = 0; set up round 1 for the next cycle.
          state    <= state ^ rk_i;
          cnt      <= 4'd1;
          rk_idx   <= 4'd1;
          rnd_last <= (NR == 4'd1);
          fsm      <= ROUND;
        end

        ROUND: begin
          state <= rnd_state_i;
          if (cnt == NR) begin
            rnd_last    <= 1'b0;
            rk_idx      <= '0;
            out_valid_q <= 1'b1;
            fsm         <= DONE;
          end else begin
            cnt      <= cnt + 4'd1;
            rk_idx   <= cnt + 4'd1;
            rnd_last <= ((cnt + 4'd1) == NR);
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm         <= IDLE;
          end
        end

        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
module tb_aes_iter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic done_a = 1'b0;
  logic done_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C2 = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- behavioural AES reference pieces ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gm(sq, sq);
      inv = gm(inv, sq);       // accumulates a^254 = a^-1 (0 maps to 0)
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
  endfunction

  function automatic logic [14:0][127:0] kexp(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [14:0][127:0] ks;
    ks = '0;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[(nk-1-i)*32 +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] b0, b1, b2, b3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sb(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      b0 = b[4*c]; b1 = b[4*c+1]; b2 = b[4*c+2]; b3 = b[4*c+3];
      if (last) begin
        a[4*c] = b0; a[4*c+1] = b1; a[4*c+2] = b2; a[4*c+3] = b3;
      end else begin
        a[4*c]   = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
        a[4*c+1] = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
        a[4*c+2] = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
        a[4*c+3] = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o ^ k;
  endfunction

  // ---------------- DUT A: AES-128 ----------------
  aes_iter_ctrl_if #(.Nkb(128)) ifa ();
  logic         ks_start_a, ks_done_a, rnd_last_a;
  logic [127:0] ks_key_a, rk_i_a, rnd_o_a, rnd_i_a;
  logic [3:0]   rk_idx_a;
  logic [14:0][127:0] sch_a;
  logic [1:0]   kc_a;
  logic         kr_a;

  aes_iter_ctrl #(.Nk(4), .Nr(10)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa),
    .ks_start(ks_start_a), .ks_key(ks_key_a), .ks_done(ks_done_a),
    .rk_idx(rk_idx_a), .rk_i(rk_i_a), .rnd_state_o(rnd_o_a),
    .rnd_last(rnd_last_a), .rnd_state_i(rnd_i_a)
  );

  // Expander model: ks_done is a level that rises 3 cycles after the ks_start edge.
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      kc_a <= 2'd0;
      kr_a <= 1'b0;
    end else if (ks_start_a) begin
      sch_a <= kexp({128'b0, ks_key_a}, 4, 10);
      kc_a  <= 2'd2;
      kr_a  <= 1'b0;
    end else if (kc_a != 2'd0) begin
      kc_a <= kc_a - 2'd1;
      if (kc_a == 2'd1) kr_a <= 1'b1;
    end
  end
  assign ks_done_a = kr_a;
  assign rk_i_a    = sch_a[rk_idx_a];
  assign rnd_i_a   = aes_rnd(rnd_o_a, rk_i_a, rnd_last_a);

  // ---------------- DUT B: AES-256 ----------------
  aes_iter_ctrl_if #(.Nkb(256)) ifb ();
  logic         ks_start_b, ks_done_b, rnd_last_b;
  logic [255:0] ks_key_b;
  logic [127:0] rk_i_b, rnd_o_b, rnd_i_b;
  logic [3:0]   rk_idx_b;
  logic [14:0][127:0] sch_b;
  logic [1:0]   kc_b;
  logic         kr_b;

  aes_iter_ctrl #(.Nk(8), .Nr(14)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb),
    .ks_start(ks_start_b), .ks_key(ks_key_b), .ks_done(ks_done_b),
    .rk_idx(rk_idx_b), .rk_i(rk_i_b), .rnd_state_o(rnd_o_b),
    .rnd_last(rnd_last_b), .rnd_state_i(rnd_i_b)
  );

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      kc_b <= 2'd0;
      kr_b <= 1'b0;
    end else if (ks_start_b) begin
      sch_b <= kexp(ks_key_b, 8, 14);
      kc_b  <= 2'd2;
      kr_b  <= 1'b0;
    end else if (kc_b != 2'd0) begin
      kc_b <= kc_b - 2'd1;
      if (kc_b == 2'd1) kr_b <= 1'b1;
    end
  end
  assign ks_done_b = kr_b;
  assign rk_i_b    = sch_b[rk_idx_b];
  assign rnd_i_b   = aes_rnd(rnd_o_b, rk_i_b, rnd_last_b);

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] data;
    int           lat;   // edges from accept to out_valid rising
    int           kst;   // ks_start pulses seen for this request
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor A
  initial begin : mon_a
    exp_t e;
    int   acc, lat, kst;
    logic ov_d;
    acc = 0; lat = -1; kst = 0; ov_d = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        ov_d = 1'b0;
        kst  = 0;
      end else begin
        if (ks_start_a) kst++;
        if (ifa.in_valid && ifa.in_ready) begin
          acc = cyc + 1;
          kst = 0;
        end
        if (ifa.out_valid && !ov_d) lat = cyc - acc;
        ov_d = ifa.out_valid;
        if (ifa.out_valid && ifa.out_ready) begin
          if (qa.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_unexpected_output: got %h with no request pending", ifa.out_data);
          end else begin
            e = qa.pop_front();
            chk("a_out_data", ifa.out_data, e.data);
            chk("a_latency", 128'(lat), 128'(e.lat));
            chk("a_ks_start_count", 128'(kst), 128'(e.kst));
          end
        end
      end
    end
  end

  // Monitor B, also tracks the round-key sweep
  initial begin : mon_b
    exp_t e;
    int   acc, lat, kst, nlast, lastidx;
    logic ov_d, busy;
    logic [15:0] mask;
    acc = 0; lat = -1; kst = 0; ov_d = 1'b0; busy = 1'b0;
    mask = '0; nlast = 0; lastidx = -1;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        ov_d = 1'b0;
        busy = 1'b0;
      end else begin
        if (busy) begin
          mask[rk_idx_b] = 1'b1;
          if (rnd_last_b) begin
            nlast++;
            lastidx = int'(rk_idx_b);
          end
        end
        if (ks_start_b) kst++;
        if (ifb.in_valid && ifb.in_ready) begin
          acc = cyc + 1; kst = 0; busy = 1'b1;
          mask = '0; nlast = 0; lastidx = -1;
        end
        if (ifb.out_valid && !ov_d) begin
          lat  = cyc - acc;
          busy = 1'b0;
          chk("b_rk_idx_sweep", 128'(mask), 128'h7fff);
          chk("b_rnd_last_count", 128'(nlast), 128'd1);
          chk("b_rnd_last_idx", 128'(lastidx), 128'd14);
        end
        ov_d = ifb.out_valid;
        if (ifb.out_valid && ifb.out_ready) begin
          if (qb.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected_output: got %h with no request pending", ifb.out_data);
          end else begin
            e = qb.pop_front();
            chk("b_out_data", ifb.out_data, e.data);
            chk("b_latency", 128'(lat), 128'(e.lat));
            chk("b_ks_start_count", 128'(kst), 128'(e.kst));
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_a(input logic [127:0] pt, input logic [127:0] key, input logic reuse);
    int   n;
    logic rdy;
    ifa.in_data = pt; ifa.in_key = key; ifa.in_key_reuse = reuse; ifa.in_valid = 1'b1;
    n = 0;
    do begin
      rdy = ifa.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 500);
    ifa.in_valid = 1'b0;
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL a_accept_timeout: got no accept in %0d cycles, required accept", n);
    end
  endtask

  task automatic send_b(input logic [127:0] pt, input logic [255:0] key, input logic reuse);
    int   n;
    logic rdy;
    ifb.in_data = pt; ifb.in_key = key; ifb.in_key_reuse = reuse; ifb.in_valid = 1'b1;
    n = 0;
    do begin
      rdy = ifb.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 500);
    ifb.in_valid = 1'b0;
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL b_accept_timeout: got no accept in %0d cycles, required accept", n);
    end
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_drain_pending", 128'(qa.size()), 128'd0);
  endtask

  task automatic drain_b();
    int n;
    n = 0;
    while (qb.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_drain_pending", 128'(qb.size()), 128'd0);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_in_ready"},  128'(ifa.in_ready), 128'd1);
    chk({tag, "_out_valid"}, 128'(ifa.out_valid), 128'd0);
    chk({tag, "_ks_start"},  128'(ks_start_a), 128'd0);
    chk({tag, "_out_data"},  ifa.out_data, 128'd0);
    chk({tag, "_rnd_state"}, rnd_o_a, 128'd0);
    chk({tag, "_ks_key"},    ks_key_a, 128'd0);
    chk({tag, "_rk_idx"},    128'(rk_idx_a), 128'd0);
    chk({tag, "_rnd_last"},  128'(rnd_last_a), 128'd0);
  endtask

  // ---------------- stimulus A ----------------
  initial begin : stim_a
    int   n, bad;
    logic rdy;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_key = '0;
    ifa.in_key_reuse = 1'b0; ifa.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_a("a_reset");
    rst_a = 1'b0;
    @(posedge clk); #1;

    // Reuse straight after reset still expands.
    qa.push_back('{C1, 15, 1});
    send_a(P1, K1, 1'b1);
    drain_a();

    // New all-zero key.
    qa.push_back('{C0, 15, 1});
    send_a('0, '0, 1'b0);
    drain_a();

    // Reuse the zero key: no expansion, Nr+1 edges.
    qa.push_back('{C0, 11, 0});
    send_a('0, '0, 1'b1);
    drain_a();

    // New key with the consumer stalled for 20 cycles in DONE.
    ifa.out_ready = 1'b0;
    qa.push_back('{C1, 15, 1});
    send_a(P1, K1, 1'b0);
    n = 0;
    while (!ifa.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    qa.push_back('{C1, 11, 0});
    ifa.in_data = P1; ifa.in_key = K1; ifa.in_key_reuse = 1'b1; ifa.in_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ifa.out_valid !== 1'b1 || ifa.out_data !== C1 || ifa.in_ready !== 1'b0) bad++;
    end
    chk("a_stall_hold_bad_cycles", 128'(bad), 128'd0);
    ifa.out_ready = 1'b1;
    n = 0;
    do begin
      rdy = ifa.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    ifa.in_valid = 1'b0;
    chk("a_stall_accept_edge", 128'(n), 128'd2);
    drain_a();

    // Reset during round 5 aborts the request and forgets the key.
    send_a(P1, K1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("a_rk_idx_round5", 128'(rk_idx_a), 128'd5);
    #1 rst_a = 1'b1;
    #1;
    chk_reset_a("a_midreset");
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(posedge clk); #1;
    qa.push_back('{C1, 15, 1});
    send_a(P1, K1, 1'b1);
    drain_a();

    done_a = 1'b1;
  end

  // ---------------- stimulus B ----------------
  initial begin : stim_b
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_key = '0;
    ifb.in_key_reuse = 1'b0; ifb.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b_reset_in_ready", 128'(ifb.in_ready), 128'd1);
    chk("b_reset_out_valid", 128'(ifb.out_valid), 128'd0);
    rst_b = 1'b0;
    @(posedge clk); #1;

    qb.push_back('{C2, 19, 1});
    send_b(P1, K2, 1'b0);
    drain_b();

    qb.push_back('{C2, 15, 0});
    send_b(P1, K2, 1'b1);
    drain_b();

    done_b = 1'b1;
  end

  // ---------------- end of test ----------------
  initial begin : finisher
    wait (done_a && done_b);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_iter_ctrl.md
Name: aes_iter_ctrl

Overview:
- Sequencing controller for an iterative AES encryption core. It time-multiplexes one external single-round datapath over Nr rounds and drives an external key-expansion unit.
- Accepts plaintext/key over a valid/ready handshake and returns ciphertext over a valid/ready handshake.
- Sits between the system bus adapter and the round/key-schedule datapath. It replaces the fully unrolled combinational cipher wherever area matters.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8 for AES-128/192/256); Nkb = Nk*32.
- Nr, 10, number of rounds (10/12/14). Must match Nk; a mismatch is not checked.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_data  in  128  plaintext, MSB = byte 0.
- in_key  in  Nkb  cipher key.
- in_key_reuse  in  1  1 = use the previously expanded key and skip expansion.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext (state register).
- ks_start  out  1  one-cycle pulse: expand ks_key.
- ks_key  out  Nkb  registered copy of in_key.
- ks_done  in  1  expansion complete (level or pulse).
- rk_idx  out  4  round-key index 0..Nr into the expanded schedule.
- rk_i  in  128  round key rk_idx, combinational from the expander.
- rnd_state_o  out  128  state fed to the round datapath (= state register).
- rnd_last  out  1  final round: datapath omits MixColumns.
- rnd_state_i  in  128  round datapath result (SubBytes/ShiftRows/[MixColumns]/AddRoundKey using rk_i).

Behaviour:
- Reset values:
  - FSM = IDLE, in_ready = 1, out_valid = 0, ks_start = 0.
  - State register and ks_key = 0, rk_idx = 0, rnd_last = 0.
  - Internal key_ok flag = 0.
- Reset is honoured mid-operation: it aborts any transaction, drops out_valid, and clears key_ok so the next request re-expands.
- FSM states: IDLE, KEXP, WAITK, ADD0, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture in_data into the state register and in_key into ks_key.
  - If in_key_reuse & key_ok, go to ADD0. Otherwise clear key_ok and go to KEXP.
  - in_key_reuse with key_ok = 0 is treated as a new key.
- in_ready = 1 only in IDLE. A request is never accepted while out_valid is high.
- KEXP: ks_start = 1 for exactly this one cycle, then go to WAITK.
- WAITK:
  - ks_done is ignored in KEXP and sampled only in WAITK.
  - On ks_done, set key_ok = 1 and go to ADD0.
  - The controller waits indefinitely; there is no timeout.
- ADD0: rk_idx = 0; state <= state ^ rk_i; go to ROUND with round counter = 1.
- ROUND:
  - rk_idx = counter; rnd_last = (counter == Nr); state <= rnd_state_i.
  - If counter == Nr, go to DONE. Otherwise increment counter.
  - The counter is 4 bits and never exceeds Nr.
- DONE:
  - out_valid = 1; out_data is held stable.
  - On out_ready, go to IDLE and drop out_valid next cycle.
  - out_ready while out_valid = 0 has no effect.
- Latency, key reuse: out_valid rises Nr+1 clock edges after the accepting edge (11 for AES-128).
- Latency, new key: add 1 (KEXP) plus the WAITK cycles; a minimum of 1 if ks_done is already high on entering WAITK.
- Back-to-back throughput with reuse and out_ready held high: one result every Nr+3 cycles (accept, ADD0, Nr rounds, DONE).
- rk_idx and rnd_last are registered; they are valid during the cycle their FSM state is active.
- rnd_state_o always equals the state register.

Test Plan:
- Bench setup: behavioural FIPS-197 round and key-expansion models attached; the expander asserts ks_done 3 cycles after ks_start.
- Reset then AES-128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, reuse = 0 -> exactly one ks_start pulse; out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises 11+1+3 edges after accept.
- Same key, reuse = 1, pt 00000000000000000000000000000000 with key 0 previously expanded -> no ks_start; out_data 66e94bd4ef8a2c3b884cfa59ca342b2e after exactly 11 edges.
- reuse = 1 immediately after reset -> expansion is still performed (ks_start seen); result correct.
- Hold out_ready = 0 for 20 cycles in DONE -> out_valid and out_data stable; in_ready = 0; a new in_valid is not accepted until the cycle after out_ready.
- Assert rst during round 5 -> all outputs return to reset values asynchronously; the next request with reuse = 1 triggers re-expansion and produces the correct ciphertext.
- Nk = 8, Nr = 14, key 000102…1f, pt 00112233445566778899aabbccddeeff -> out_data 8ea2b7ca516745bfeafc49904b496089; rk_idx sweeps 0..14; rnd_last high only at index 14.
